// File: rtl/uart_rx_pkg.sv
// Shared state encoding and constants for the UART receive controller.
package uart_rx_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int BIT_CNT_W  = 4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter with wrap-driven bit counter; both held at 0 while disabled.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [4:0]           prescale,
  output logic [4:0]           edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 end_of_bit
);

  assign end_of_bit = enable && (edge_cnt == (prescale - 5'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (!enable) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (end_of_bit) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 1'b1;
    end else begin
      edge_cnt <= edge_cnt + 5'd1;
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, LSB-first deserialize, parity/stop check.
//   state  | meaning
//   IDLE   | line idle, waiting for rx_in low
//   START  | start bit; high vote at end of bit is a glitch
//   DATA   | shifting in DATA_WIDTH payload bits
//   PARITY | checking optional parity bit
//   STOP   | checking stop bit, strobing good bytes
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = uart_rx_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [4:0]            prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic                  sampled_bit,
  output logic                  en_sampler,
  output logic [4:0]            edge_cnt,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  rx_state_t             state_q, state_d;
  logic [4:0]            prescale_q;
  logic                  par_en_q, par_typ_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic                  end_of_bit;
  logic                  start_det;
  logic                  par_exp;

  assign start_det = (state_q == IDLE) && !rx_in;

  uart_rx_edge_bit_counter u_cnt (
    .clk        (clk),
    .rst        (rst),
    .enable     (state_q != IDLE),
    .prescale   (prescale_q),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .end_of_bit (end_of_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (!rx_in) state_d = START;
      START:  if (end_of_bit) state_d = sampled_bit ? IDLE : DATA;
      DATA:   if (end_of_bit && (bit_cnt == BIT_CNT_W'(DATA_WIDTH)))
                state_d = par_en_q ? PARITY : STOP;
      PARITY: if (end_of_bit) state_d = STOP;
      STOP:   if (end_of_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    par_exp = ^shift_q;
    case (par_typ_q)
      PAR_EVEN: par_exp = ^shift_q;
      PAR_ODD:  par_exp = ~^shift_q;
      default:  ;
    endcase
  end

  // Frame configuration is frozen at start detection so mid-frame changes are ignored.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      shift_q    <= '0;
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      en_sampler <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      en_sampler <= (state_d != IDLE);
      if (start_det) begin
        prescale_q <= prescale;
        par_en_q   <= par_en;
        par_typ_q  <= par_typ;
        par_err    <= 1'b0;
        stp_err    <= 1'b0;
      end
      if (end_of_bit) begin
        case (state_q)
          DATA:   shift_q <= {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          PARITY: par_err <= (sampled_bit != par_exp);
          STOP: begin
            stp_err <= ~sampled_bit;
            if (!par_err && sampled_bit) begin
              p_data     <= shift_q;
              data_valid <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl with a 3-sample majority-vote sampler and a strobe scoreboard.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_in;
  logic [4:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       sampled_bit;
  logic       en_sampler;
  logic [4:0] edge_cnt;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  uart_rx_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .rx_in       (rx_in),
    .prescale    (prescale),
    .par_en      (par_en),
    .par_typ     (par_typ),
    .sampled_bit (sampled_bit),
    .en_sampler  (en_sampler),
    .edge_cnt    (edge_cnt),
    .p_data      (p_data),
    .data_valid  (data_valid),
    .par_err     (par_err),
    .stp_err     (stp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // majority-vote sampler around mid-bit
  logic [2:0] smp = 3'b111;
  always @(posedge clk) begin
    if (en_sampler) begin
      if (edge_cnt == (prescale >> 1) - 5'd1) smp[0] <= rx_in;
      if (edge_cnt == (prescale >> 1))        smp[1] <= rx_in;
      if (edge_cnt == (prescale >> 1) + 5'd1) smp[2] <= rx_in;
    end
  end
  assign sampled_bit = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic [4:0] ps;
    logic       pe;
    logic       pt;
    logic [7:0] data;
    logic       bad_par;
    logic       stop_bit;
    logic       exp_valid;
    logic       exp_par_err;
    logic       exp_stp_err;
    logic [7:0] exp_pdata;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1 && data_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got strobe p_data=%0h expected none (cycle %0d)", p_data, cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("strobe_cycle", cyc, e.cyc);
        check("strobe_data", {24'd0, p_data}, {24'd0, e.data});
      end
    end
  end

  // Called at a negedge while the controller is idle; each bit is held for ps cycles.
  task automatic send_frame(input logic [4:0] ps, input logic pe, input logic pt,
                            input logic [7:0] d, input logic bad_par, input logic stop_bit);
    logic pbit;
    pbit = (pt ? ~^d : ^d) ^ bad_par;
    prescale = ps;
    par_en   = pe;
    par_typ  = pt;
    rx_in    = 1'b0;
    repeat (ps) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_in = d[i];
      repeat (ps) @(negedge clk);
    end
    if (pe) begin
      rx_in = pbit;
      repeat (ps) @(negedge clk);
    end
    rx_in = stop_bit;
    repeat (ps) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t0;
    int nbits;
    logic [7:0] part;

    vecs[0] = '{5'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5};
    vecs[1] = '{5'd8,  1'b1, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h0F};
    vecs[2] = '{5'd8,  1'b1, 1'b0, 8'h0F, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h0F};
    vecs[3] = '{5'd8,  1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h0F};
    vecs[4] = '{5'd16, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};

    rst = 1'b0; rx_in = 1'b1; prescale = 5'd8; par_en = 1'b0; par_typ = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_en_sampler", en_sampler, 0);
    check("rst_edge_cnt", edge_cnt, 0);
    check("rst_p_data", p_data, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_par_err", par_err, 0);
    check("rst_stp_err", stp_err, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      nbits = 10 + int'(vecs[i].pe);
      t0 = cyc;
      if (vecs[i].exp_valid)
        sb_q.push_back('{t0 + nbits * int'(vecs[i].ps) + 1, vecs[i].data});
      send_frame(vecs[i].ps, vecs[i].pe, vecs[i].pt, vecs[i].data, vecs[i].bad_par, vecs[i].stop_bit);
      rx_in = 1'b1;
      @(negedge clk);
      check("vec_data_valid", data_valid, vecs[i].exp_valid);
      check("vec_en_sampler_idle", en_sampler, 0);
      check("vec_edge_cnt_idle", edge_cnt, 0);
      check("vec_par_err", par_err, vecs[i].exp_par_err);
      check("vec_stp_err", stp_err, vecs[i].exp_stp_err);
      check("vec_p_data", p_data, vecs[i].exp_pdata);
      repeat (3) @(negedge clk);
    end

    // back-to-back frames at prescale 16, odd parity: second start is seen the cycle IDLE returns
    t0 = cyc;
    sb_q.push_back('{t0 + 177, 8'h00});
    sb_q.push_back('{t0 + 354, 8'hFF});
    send_frame(5'd16, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1);
    send_frame(5'd16, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
    rx_in = 1'b1;
    repeat (2) @(negedge clk);
    check("b2b_data_valid", data_valid, 1);
    check("b2b_p_data", p_data, 8'hFF);
    check("b2b_par_err", par_err, 0);
    check("b2b_stp_err", stp_err, 0);
    repeat (3) @(negedge clk);

    // start glitch: low for 2 cycles only
    prescale = 5'd8; par_en = 1'b0;
    rx_in = 1'b0;
    repeat (2) @(negedge clk);
    rx_in = 1'b1;
    repeat (6) @(negedge clk);
    check("glitch_en_in_start", en_sampler, 1);
    check("glitch_edge_last", edge_cnt, 7);
    @(negedge clk);
    check("glitch_en_sampler", en_sampler, 0);
    check("glitch_edge_cnt", edge_cnt, 0);
    check("glitch_par_err", par_err, 0);
    check("glitch_stp_err", stp_err, 0);
    check("glitch_p_data", p_data, 8'hFF);
    repeat (3) @(negedge clk);

    // reset asserted in the middle of data bit 4
    part = 8'h5A;
    rx_in = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx_in = part[i];
      repeat (8) @(negedge clk);
    end
    rx_in = part[4];
    repeat (3) @(negedge clk);
    check("mid_en_sampler", en_sampler, 1);
    check("mid_edge_cnt", edge_cnt, 2);
    rst = 1'b0;
    #1;
    check("arst_en_sampler", en_sampler, 0);
    check("arst_edge_cnt", edge_cnt, 0);
    check("arst_p_data", p_data, 0);
    check("arst_data_valid", data_valid, 0);
    check("arst_par_err", par_err, 0);
    check("arst_stp_err", stp_err, 0);
    @(negedge clk);
    rx_in = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    t0 = cyc;
    sb_q.push_back('{t0 + 81, 8'h81});
    send_frame(5'd8, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1);
    rx_in = 1'b1;
    @(negedge clk);
    check("post_rst_p_data", p_data, 8'h81);
    check("post_rst_par_err", par_err, 0);
    check("post_rst_stp_err", stp_err, 0);
    repeat (5) @(negedge clk);

    check("pending_strobes", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
